// File: rtl/tl_a_source_arbiter_if.sv
// One TileLink-UL A/D link between a requester and a responder.
// SRC_W is 6 on the requester side and 7 on the shared fabric side.
interface tl_a_source_arbiter_if #(
    parameter int ADDR_W     = 30,
    parameter int DATA_BYTES = 8,
    parameter int SRC_W      = 6
);
    logic                    a_valid;
    logic                    a_ready;
    logic [2:0]              a_opcode;
    logic [2:0]              a_param;
    logic [3:0]              a_size;
    logic [SRC_W-1:0]        a_source;
    logic [ADDR_W-1:0]       a_address;
    logic [DATA_BYTES-1:0]   a_mask;
    logic [8*DATA_BYTES-1:0] a_data;

    logic                    d_valid;
    logic                    d_ready;
    logic [2:0]              d_opcode;
    logic [2:0]              d_param;
    logic [3:0]              d_size;
    logic [SRC_W-1:0]        d_source;
    logic                    d_denied;
    logic                    d_corrupt;
    logic [8*DATA_BYTES-1:0] d_data;

    // Requester side: issues A, accepts D
    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data,
        output d_ready
    );

    // Responder side: accepts A, issues D
    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data,
        input  d_ready
    );
endinterface

// File: rtl/tl_a_source_arbiter.sv
// Two-requester TileLink-UL A-channel arbiter with D-channel return routing.
// The granted requester index is carried in out.a_source[6] and D beats are
// steered back by the same bit. Bursts hold the grant until their last beat.
module tl_a_source_arbiter #(
    parameter int ADDR_W     = 30,
    parameter int DATA_BYTES = 8,
    parameter int MAX_SIZE   = 6,
    parameter int MAX_OUT    = 4
) (
    input  logic clock,
    input  logic reset,
    tl_a_source_arbiter_if.slave  in0,
    tl_a_source_arbiter_if.slave  in1,
    tl_a_source_arbiter_if.master out,
    output logic protocol_err
);
    localparam int LG_BEAT = $clog2(DATA_BYTES);
    localparam int CNT_W   = $clog2(MAX_OUT + 1);
    // Wide enough for 2^(15-LG_BEAT) beats so illegal sizes still count sanely
    localparam int BEAT_W  = 13;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BURST} state_t;

    state_t              r_state;
    logic                r_grant;
    logic                r_rr;
    logic [BEAT_W-1:0]   r_abeat;
    logic [BEAT_W-1:0]   r_dbeat;
    logic [CNT_W-1:0]    r_cnt0;
    logic [CNT_W-1:0]    r_cnt1;
    logic                r_err;

    logic                    w_elig0, w_elig1;
    logic                    w_sel, w_sel_valid, w_sel_elig;
    logic                    w_a_fire, w_a_first, w_a_last;
    logic [2:0]              w_a_opcode;
    logic [3:0]              w_a_size;
    logic [BEAT_W-1:0]       w_a_beats;
    logic [ADDR_W-1:0]       w_a_address;
    logic [DATA_BYTES-1:0]   w_a_mask;
    logic [8*DATA_BYTES-1:0] w_a_data;
    logic                    w_d_sel, w_d_fire, w_d_last;
    logic [BEAT_W-1:0]       w_d_beats;
    logic                    w_inc0, w_inc1, w_dec0, w_dec1, w_uflow;

    // Number of beats in a message; only multi-beat opcodes with size above one beat expand
    function automatic logic [BEAT_W-1:0] beats(input logic multi, input logic [3:0] size);
        if (multi && (size > 4'(LG_BEAT)))
            return BEAT_W'(1) << (size - 4'(LG_BEAT));
        return BEAT_W'(1);
    endfunction

    assign w_elig0 = in0.a_valid && (r_cnt0 < CNT_W'(MAX_OUT));
    assign w_elig1 = in1.a_valid && (r_cnt1 < CNT_W'(MAX_OUT));

    // Grant select: round-robin among eligible requesters when idle, frozen otherwise
    always_comb begin
        w_sel = r_grant;
        if (r_state == S_IDLE) begin
            if (w_elig0 && w_elig1)
                w_sel = r_rr;
            else
                w_sel = w_elig1;
        end
    end

    assign w_sel_valid = w_sel ? in1.a_valid : in0.a_valid;
    assign w_sel_elig  = w_sel ? w_elig1 : w_elig0;

    assign w_a_opcode  = w_sel ? in1.a_opcode  : in0.a_opcode;
    assign w_a_size    = w_sel ? in1.a_size    : in0.a_size;
    assign w_a_address = w_sel ? in1.a_address : in0.a_address;
    assign w_a_mask    = w_sel ? in1.a_mask    : in0.a_mask;
    assign w_a_data    = w_sel ? in1.a_data    : in0.a_data;

    assign out.a_valid   = (r_state == S_IDLE) ? w_sel_elig : w_sel_valid;
    assign out.a_opcode  = w_a_opcode;
    assign out.a_param   = w_sel ? in1.a_param : in0.a_param;
    assign out.a_size    = w_a_size;
    assign out.a_source  = {w_sel, (w_sel ? in1.a_source : in0.a_source)};
    assign out.a_address = w_a_address;
    assign out.a_mask    = w_a_mask;
    assign out.a_data    = w_a_data;

    assign in0.a_ready = out.a_ready && !w_sel && ((r_state != S_IDLE) || w_elig0);
    assign in1.a_ready = out.a_ready &&  w_sel && ((r_state != S_IDLE) || w_elig1);

    assign w_a_fire  = out.a_valid && out.a_ready;
    assign w_a_first = (r_abeat == '0);
    assign w_a_beats = beats((w_a_opcode == 3'd0) || (w_a_opcode == 3'd1), w_a_size);
    assign w_a_last  = ((r_abeat + BEAT_W'(1)) == w_a_beats);

    // D return path: steer by the requester tag in source bit 6
    assign w_d_sel       = out.d_source[6];
    assign out.d_ready   = w_d_sel ? in1.d_ready : in0.d_ready;
    assign in0.d_valid   = out.d_valid && !w_d_sel;
    assign in1.d_valid   = out.d_valid &&  w_d_sel;
    assign in0.d_opcode  = out.d_opcode;
    assign in1.d_opcode  = out.d_opcode;
    assign in0.d_param   = out.d_param;
    assign in1.d_param   = out.d_param;
    assign in0.d_size    = out.d_size;
    assign in1.d_size    = out.d_size;
    assign in0.d_source  = out.d_source[5:0];
    assign in1.d_source  = out.d_source[5:0];
    assign in0.d_denied  = out.d_denied;
    assign in1.d_denied  = out.d_denied;
    assign in0.d_corrupt = out.d_corrupt;
    assign in1.d_corrupt = out.d_corrupt;
    assign in0.d_data    = out.d_data;
    assign in1.d_data    = out.d_data;

    assign w_d_fire  = out.d_valid && out.d_ready;
    assign w_d_beats = beats(out.d_opcode == 3'd1, out.d_size);
    assign w_d_last  = ((r_dbeat + BEAT_W'(1)) == w_d_beats);

    assign w_inc0  = w_a_fire && w_a_first && !w_sel;
    assign w_inc1  = w_a_fire && w_a_first &&  w_sel;
    assign w_dec0  = w_d_fire && w_d_last && !w_d_sel;
    assign w_dec1  = w_d_fire && w_d_last &&  w_d_sel;
    assign w_uflow = (w_dec0 && !w_inc0 && (r_cnt0 == '0)) ||
                     (w_dec1 && !w_inc1 && (r_cnt1 == '0));

    // Arbiter FSM: grant lock across stalls and bursts, round-robin pointer update
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_rr    <= 1'b0;
            r_abeat <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_grant <= w_sel;
                    if (w_a_fire) begin
                        if (w_a_last) begin
                            r_rr <= ~w_sel;
                        end else begin
                            r_state <= S_BURST;
                            r_abeat <= BEAT_W'(1);
                        end
                    end else if (out.a_valid) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_a_fire) begin
                        if (w_a_last) begin
                            r_state <= S_IDLE;
                            r_rr    <= ~w_sel;
                        end else begin
                            r_state <= S_BURST;
                            r_abeat <= BEAT_W'(1);
                        end
                    end
                end
                S_BURST: begin
                    if (w_a_fire) begin
                        if (w_a_last) begin
                            r_state <= S_IDLE;
                            r_abeat <= '0;
                            r_rr    <= ~w_sel;
                        end else begin
                            r_abeat <= r_abeat + BEAT_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // D beat counter; D bursts never interleave so one counter serves both requesters
    always_ff @(posedge clock) begin
        if (reset)
            r_dbeat <= '0;
        else if (w_d_fire)
            r_dbeat <= w_d_last ? '0 : (r_dbeat + BEAT_W'(1));
    end

    // Outstanding transaction counters; a decrement at zero holds zero
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_inc0 && !w_dec0)
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            else if (w_dec0 && !w_inc0 && (r_cnt0 != '0))
                r_cnt0 <= r_cnt0 - CNT_W'(1);
            if (w_inc1 && !w_dec1)
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            else if (w_dec1 && !w_inc1 && (r_cnt1 != '0))
                r_cnt1 <= r_cnt1 - CNT_W'(1);
        end
    end

    // Sticky protocol error: counter underflow or oversized A/D message
    always_ff @(posedge clock) begin
        if (reset)
            r_err <= 1'b0;
        else if (w_uflow ||
                 (w_a_fire && w_a_first && (w_a_size > 4'(MAX_SIZE))) ||
                 (w_d_fire && (out.d_size > 4'(MAX_SIZE))))
            r_err <= 1'b1;
    end

    assign protocol_err = r_err;
endmodule

// File: tb/tb_tl_a_source_arbiter.sv
// Bench for tl_a_source_arbiter: transaction-level reference model checked on
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_tl_a_source_arbiter;
    localparam int ADDR_W     = 30;
    localparam int DATA_BYTES = 8;
    localparam int MAX_SIZE   = 6;
    localparam int MAX_OUT    = 4;
    localparam int LG_BEAT    = 3;

    logic clock = 1'b0;
    logic reset;
    logic protocol_err;

    always #5 clock = ~clock;

    tl_a_source_arbiter_if #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .SRC_W(6)) if_in0 ();
    tl_a_source_arbiter_if #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .SRC_W(6)) if_in1 ();
    tl_a_source_arbiter_if #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .SRC_W(7)) if_out ();

    tl_a_source_arbiter #(
        .ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .MAX_SIZE(MAX_SIZE), .MAX_OUT(MAX_OUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in0(if_in0),
        .in1(if_in1),
        .out(if_out),
        .protocol_err(protocol_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int owner = -1;   // requester holding the channel, -1 when free
    int done_b = 0;   // beats already sent of the current A message
    int pref = 0;     // requester favoured on a tie
    int ddone = 0;    // beats already seen of the current D message
    int cnt[2] = '{0, 0};
    bit err_m = 1'b0;

    initial begin : model
        bit              v[2];
        bit              elig[2];
        bit              rdy[2];
        bit              inc[2];
        bit              dec[2];
        logic [2:0]      op[2];
        logic [2:0]      prm[2];
        logic [3:0]      sz[2];
        logic [5:0]      src[2];
        logic [29:0]     ad[2];
        logic [7:0]      msk[2];
        logic [63:0]     dat[2];
        int              sel, dd, nb;
        bit              ov, dr;
        forever begin
            @(negedge clock);
            v[0] = if_in0.a_valid;     v[1] = if_in1.a_valid;
            op[0] = if_in0.a_opcode;   op[1] = if_in1.a_opcode;
            prm[0] = if_in0.a_param;   prm[1] = if_in1.a_param;
            sz[0] = if_in0.a_size;     sz[1] = if_in1.a_size;
            src[0] = if_in0.a_source;  src[1] = if_in1.a_source;
            ad[0] = if_in0.a_address;  ad[1] = if_in1.a_address;
            msk[0] = if_in0.a_mask;    msk[1] = if_in1.a_mask;
            dat[0] = if_in0.a_data;    dat[1] = if_in1.a_data;
            for (int i = 0; i < 2; i++) elig[i] = v[i] && (cnt[i] < MAX_OUT);
            if (owner < 0) begin
                sel = (elig[0] && elig[1]) ? pref : (elig[1] ? 1 : 0);
                ov  = elig[sel];
            end else begin
                sel = owner;
                ov  = v[sel];
            end
            for (int i = 0; i < 2; i++)
                rdy[i] = if_out.a_ready && (sel == i) && ((owner >= 0) || elig[i]);

            check("m_out_a_valid", 64'(if_out.a_valid), 64'(ov));
            check("m_in0_a_ready", 64'(if_in0.a_ready), 64'(rdy[0]));
            check("m_in1_a_ready", 64'(if_in1.a_ready), 64'(rdy[1]));
            if (ov) begin
                check("m_out_a_source",  64'(if_out.a_source),  64'({sel[0], src[sel]}));
                check("m_out_a_opcode",  64'(if_out.a_opcode),  64'(op[sel]));
                check("m_out_a_param",   64'(if_out.a_param),   64'(prm[sel]));
                check("m_out_a_size",    64'(if_out.a_size),    64'(sz[sel]));
                check("m_out_a_address", 64'(if_out.a_address), 64'(ad[sel]));
                check("m_out_a_mask",    64'(if_out.a_mask),    64'(msk[sel]));
                check("m_out_a_data",    if_out.a_data,         dat[sel]);
            end

            dd = int'(if_out.d_source[6]);
            dr = (dd == 1) ? if_in1.d_ready : if_in0.d_ready;
            check("m_in0_d_valid", 64'(if_in0.d_valid), 64'(if_out.d_valid && (dd == 0)));
            check("m_in1_d_valid", 64'(if_in1.d_valid), 64'(if_out.d_valid && (dd == 1)));
            check("m_out_d_ready", 64'(if_out.d_ready), 64'(dr));
            if (if_out.d_valid) begin
                check("m_d_source", 64'((dd == 1) ? if_in1.d_source : if_in0.d_source),
                      64'(if_out.d_source[5:0]));
                check("m_d_data", (dd == 1) ? if_in1.d_data : if_in0.d_data, if_out.d_data);
            end
            check("m_protocol_err", 64'(protocol_err), 64'(err_m));

            if (reset) begin
                owner = -1; done_b = 0; pref = 0; ddone = 0;
                cnt[0] = 0; cnt[1] = 0; err_m = 1'b0;
            end else begin
                inc[0] = 0; inc[1] = 0; dec[0] = 0; dec[1] = 0;
                if (ov && if_out.a_ready) begin
                    if (done_b == 0) begin
                        inc[sel] = 1;
                        if (sz[sel] > MAX_SIZE) err_m = 1'b1;
                    end
                    nb = ((op[sel] == 0 || op[sel] == 1) && sz[sel] > LG_BEAT) ?
                         (1 << (sz[sel] - LG_BEAT)) : 1;
                    done_b++;
                    if (done_b >= nb) begin
                        owner = -1; done_b = 0; pref = 1 - sel;
                    end else begin
                        owner = sel;
                    end
                end else if (ov) begin
                    owner = sel;
                end
                if (if_out.d_valid && dr) begin
                    if (if_out.d_size > MAX_SIZE) err_m = 1'b1;
                    nb = (if_out.d_opcode == 1 && if_out.d_size > LG_BEAT) ?
                         (1 << (if_out.d_size - LG_BEAT)) : 1;
                    ddone++;
                    if (ddone >= nb) begin
                        ddone = 0; dec[dd] = 1;
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (inc[i] && !dec[i]) cnt[i]++;
                    else if (dec[i] && !inc[i]) begin
                        if (cnt[i] == 0) err_m = 1'b1;
                        else cnt[i]--;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic a_drive(input int n, input bit v, input logic [2:0] op, input logic [3:0] sz,
                           input logic [5:0] src, input logic [29:0] ad);
        if (n == 0) begin
            if_in0.a_valid = v; if_in0.a_opcode = op; if_in0.a_param = 3'd0;
            if_in0.a_size = sz; if_in0.a_source = src; if_in0.a_address = ad;
            if_in0.a_mask = 8'hFF; if_in0.a_data = {32'hA0A0_0000, 2'b00, ad};
        end else begin
            if_in1.a_valid = v; if_in1.a_opcode = op; if_in1.a_param = 3'd1;
            if_in1.a_size = sz; if_in1.a_source = src; if_in1.a_address = ad;
            if_in1.a_mask = 8'h0F; if_in1.a_data = {32'hB1B1_0000, 2'b00, ad};
        end
    endtask

    task automatic a_idle(input int n);
        if (n == 0) if_in0.a_valid = 1'b0;
        else        if_in1.a_valid = 1'b0;
    endtask

    task automatic d_set(input bit v, input logic [2:0] op, input logic [3:0] sz, input logic [6:0] src);
        if_out.d_valid = v; if_out.d_opcode = op; if_out.d_param = 3'd0;
        if_out.d_size = sz; if_out.d_source = src; if_out.d_denied = 1'b0;
        if_out.d_corrupt = 1'b0; if_out.d_data = {57'h0D0D, src};
    endtask

    task automatic d_send(input logic [2:0] op, input logic [3:0] sz, input logic [6:0] src, input int nbeats);
        d_set(1'b1, op, sz, src);
        repeat (nbeats) step();
        d_set(1'b0, op, sz, src);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1;
        a_drive(0, 1'b0, 3'd4, 4'd3, 6'd0, 30'h0);
        a_drive(1, 1'b0, 3'd4, 4'd3, 6'd0, 30'h0);
        if_in0.d_ready = 1'b1;
        if_in1.d_ready = 1'b1;
        if_out.a_ready = 1'b0;
        d_set(1'b0, 3'd0, 4'd0, 7'h00);
        repeat (2) step();
        reset = 1'b0;
        #2;
        check("rst_protocol_err", 64'(protocol_err), 64'd0);
        check("rst_out_a_valid", 64'(if_out.a_valid), 64'd0);
        check("rst_in0_a_ready", 64'(if_in0.a_ready), 64'd0);

        // Single Get from in0, response routed back
        if_out.a_ready = 1'b1;
        a_drive(0, 1'b1, 3'd4, 4'd3, 6'd5, 30'h100);
        #2;
        check("t1_out_a_valid", 64'(if_out.a_valid), 64'd1);
        check("t1_out_a_source", 64'(if_out.a_source), 64'h05);
        step();
        a_idle(0);
        d_set(1'b1, 3'd1, 4'd3, 7'h05);
        #2;
        check("t1_in0_d_valid", 64'(if_in0.d_valid), 64'd1);
        check("t1_in1_d_valid", 64'(if_in1.d_valid), 64'd0);
        check("t1_in0_d_source", 64'(if_in0.d_source), 64'd5);
        step();
        d_set(1'b0, 3'd1, 4'd3, 7'h05);

        // Stall with in0 granted while the pointer favours in1: grant stays on in0
        if_out.a_ready = 1'b0;
        a_drive(0, 1'b1, 3'd4, 4'd3, 6'd7, 30'h200);
        #2;
        check("t4_src_c0", 64'(if_out.a_source), 64'h07);
        step();
        a_drive(1, 1'b1, 3'd4, 4'd3, 6'd8, 30'h300);
        for (int c = 1; c < 3; c++) begin
            #2;
            check("t4_hold_source", 64'(if_out.a_source), 64'h07);
            check("t4_hold_address", 64'(if_out.a_address), 64'h200);
            check("t4_hold_in1_ready", 64'(if_in1.a_ready), 64'd0);
            step();
        end
        if_out.a_ready = 1'b1;
        #2;
        check("t4_fire_in0_ready", 64'(if_in0.a_ready), 64'd1);
        step();
        a_idle(0);
        #2;
        check("t4_then_in1", 64'(if_out.a_source), 64'h48);
        step();
        a_idle(1);
        d_send(3'd1, 4'd3, 7'h07, 1);
        d_send(3'd1, 4'd3, 7'h48, 1);

        // Both requesters streaming single-beat Gets: grants alternate
        a_drive(0, 1'b1, 3'd4, 4'd3, 6'd1, 30'h10);
        a_drive(1, 1'b1, 3'd4, 4'd3, 6'd2, 30'h20);
        for (int k = 0; k < 4; k++) begin
            #2;
            check("t2_grant_idx", 64'(if_out.a_source[6]), 64'(k % 2));
            step();
        end
        a_idle(0);
        a_idle(1);
        d_send(3'd0, 4'd3, 7'h01, 1);
        d_send(3'd0, 4'd3, 7'h01, 1);
        d_send(3'd0, 4'd3, 7'h42, 1);
        d_send(3'd0, 4'd3, 7'h42, 1);

        // 4-beat PutFull from in0 locks out in1 until the last beat
        a_drive(0, 1'b1, 3'd0, 4'd5, 6'd3, 30'h40);
        #2;
        check("t3_beat0_grant", 64'(if_out.a_source[6]), 64'd0);
        step();
        a_drive(1, 1'b1, 3'd4, 4'd3, 6'd4, 30'h80);
        for (int b = 1; b < 4; b++) begin
            #2;
            check("t3_burst_in1_ready", 64'(if_in1.a_ready), 64'd0);
            check("t3_burst_grant", 64'(if_out.a_source[6]), 64'd0);
            step();
        end
        a_idle(0);
        #2;
        check("t3_in1_grant", 64'(if_out.a_source[6]), 64'd1);
        check("t3_in1_ready", 64'(if_in1.a_ready), 64'd1);
        step();
        a_idle(1);
        d_send(3'd0, 4'd5, 7'h03, 1);
        d_send(3'd1, 4'd4, 7'h44, 2);

        // in1 fills its outstanding limit, then one response frees a slot
        a_drive(1, 1'b1, 3'd4, 4'd3, 6'd9, 30'h400);
        for (int k = 0; k < 4; k++) begin
            #2;
            check("t5_fill_in1_ready", 64'(if_in1.a_ready), 64'd1);
            step();
        end
        #2;
        check("t5_full_valid", 64'(if_out.a_valid), 64'd0);
        check("t5_full_ready", 64'(if_in1.a_ready), 64'd0);
        step();
        d_set(1'b1, 3'd0, 4'd3, 7'h40);
        #2;
        check("t5_dcycle_valid", 64'(if_out.a_valid), 64'd0);
        step();
        d_set(1'b0, 3'd0, 4'd3, 7'h40);
        #2;
        check("t5_freed_valid", 64'(if_out.a_valid), 64'd1);
        check("t5_freed_source", 64'(if_out.a_source), 64'h49);
        step();
        a_idle(1);
        d_send(3'd1, 4'd5, 7'h49, 4);
        d_send(3'd0, 4'd3, 7'h49, 1);
        d_send(3'd0, 4'd3, 7'h49, 1);
        d_send(3'd0, 4'd3, 7'h49, 1);

        // Unsolicited response sets the sticky error; reset clears it
        #2;
        check("t6_err_before", 64'(protocol_err), 64'd0);
        d_send(3'd0, 4'd3, 7'h00, 1);
        #2;
        check("t6_err_set", 64'(protocol_err), 64'd1);
        repeat (3) step();
        #2;
        check("t6_err_sticky", 64'(protocol_err), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #2;
        check("t6_rst_err", 64'(protocol_err), 64'd0);
        check("t6_rst_out_a_valid", 64'(if_out.a_valid), 64'd0);
        check("t6_rst_in0_d_valid", 64'(if_in0.d_valid), 64'd0);
        check("t6_rst_in1_d_valid", 64'(if_in1.d_valid), 64'd0);

        // Oversized A request flags an error
        a_drive(0, 1'b1, 3'd4, 4'd7, 6'd1, 30'h0);
        step();
        a_idle(0);
        #2;
        check("t7_oversize_err", 64'(protocol_err), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Reset in the middle of an 8-beat burst returns the arbiter to idle
        a_drive(0, 1'b1, 3'd0, 4'd6, 6'd2, 30'h800);
        repeat (2) step();
        reset = 1'b1;
        a_idle(0);
        step();
        reset = 1'b0;
        a_drive(1, 1'b1, 3'd4, 4'd3, 6'd3, 30'h900);
        #2;
        check("t8_after_rst_valid", 64'(if_out.a_valid), 64'd1);
        check("t8_after_rst_source", 64'(if_out.a_source), 64'h43);
        step();
        a_idle(1);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
